// File: rtl/folded_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : folded_neuron
//  Description : Time-multiplexed fixed-point neuron computing
//                act(sum(in[i]*w[i]) + bias) over N inputs with P multipliers,
//                N/P accumulation beats per vector, valid/ready on both sides,
//                run-time activation select and saturation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module folded_neuron #(
    parameter int N  = 8,
    parameter int P  = 2,
    parameter int QM = 12,
    parameter int QN = 20,
    parameter int WM = 6,
    parameter int WN = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N-1:0][QM+QN-1:0]           in,
    input  logic [N-1:0][WM+WN-1:0]           weights,
    input  logic [QM+QN-1:0]                  bias,
    input  logic [1:0]                        act_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [QM+QN-1:0]                  out,
    output logic                              sat
);

    localparam int W     = QM + QN;
    localparam int WW    = WM + WN;
    localparam int PW    = W + WW;
    localparam int AW    = PW + $clog2(N + 1);
    localparam int BEATS = N / P;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    // Representable range of the W-bit result, sign-extended to AW bits
    localparam logic signed [AW-1:0] MAX_S = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_S = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [N-1:0][W-1:0]   in_q, in_d;
    logic [N-1:0][WW-1:0]  w_q, w_d;
    logic [1:0]            mode_q, mode_d;
    logic [W-1:0]          out_q, out_d;
    logic                  sat_q, sat_d;

    logic                  accept;
    logic                  last_beat;
    logic signed [PW-1:0]  a_ext, b_ext, prod;
    logic signed [AW-1:0]  psum;
    logic signed [AW-1:0]  shifted;
    logic signed [W-1:0]   clamped;
    logic signed [W-1:0]   activated;
    logic                  clamp_hit;

    assign accept    = in_valid & in_ready;
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign out       = out_q;
    assign sat       = sat_q;

    // State and datapath registers; reset clears control and result only
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            in_q    <= in_d;
            w_q     <= w_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept)    state_d = S_ACCUM;
            S_ACCUM:  if (last_beat) state_d = S_FINISH;
            S_FINISH:                state_d = S_OUTPUT;
            S_OUTPUT: if (out_ready) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Handshake outputs depend only on the current state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_OUTPUT);
    end

    // Partial sum of the P products selected by the current beat
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        prod  = '0;
        psum  = '0;
        for (int j = 0; j < P; j++) begin
            a_ext = {{WW{in_q[int'(beat_q) * P + j][W-1]}}, in_q[int'(beat_q) * P + j]};
            b_ext = {{W{w_q[int'(beat_q) * P + j][WW-1]}}, w_q[int'(beat_q) * P + j]};
            prod  = a_ext * b_ext;
            psum  = psum + {{(AW-PW){prod[PW-1]}}, prod};
        end
    end

    // Rescale, clamp to W bits (saturation judged before activation), activate
    always_comb begin
        shifted   = acc_q >>> WN;
        clamp_hit = 1'b0;
        clamped   = shifted[W-1:0];
        if (shifted > MAX_S) begin
            clamped   = MAX_S[W-1:0];
            clamp_hit = 1'b1;
        end else if (shifted < MIN_S) begin
            clamped   = MIN_S[W-1:0];
            clamp_hit = 1'b1;
        end
        case (mode_q)
            2'd1:    activated = clamped[W-1] ? '0 : clamped;
            2'd2:    activated = clamped[W-1] ? (clamped >>> 3) : clamped;
            default: activated = clamped;
        endcase
    end

    // Datapath register updates per state
    always_comb begin
        beat_d = beat_q;
        acc_d  = acc_q;
        in_d   = in_q;
        w_d    = w_q;
        mode_d = mode_q;
        out_d  = out_q;
        sat_d  = sat_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    in_d   = in;
                    w_d    = weights;
                    mode_d = act_mode;
                    // Bias carries QN fraction bits; products carry QN+WN
                    acc_d  = {{(AW-W-WN){bias[W-1]}}, bias, {WN{1'b0}}};
                    beat_d = '0;
                end
            end
            S_ACCUM: begin
                acc_d  = acc_q + psum;
                beat_d = last_beat ? '0 : beat_q + BW'(1);
            end
            S_FINISH: begin
                out_d = activated;
                sat_d = clamp_hit;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
